// File: rtl/dp_mem_param.sv
// Parametrised 1W/1R RAM: byte enables, read-during-write forwarding, post-reset self-clear.
// Optional per-byte even parity storage and checking when DP_MEM_PARITY_EN is defined.
module dp_mem_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic                par_inj,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [DATA_W-1:0]   r_data,
  output logic                r_valid,
  output logic                r_err,
  output logic                busy
);
  localparam int NB = DATA_W / 8;
`ifdef DP_MEM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    if (state_reg == CLEAR) begin
      clr_ptr_next = clr_ptr_reg + 1'b1;
      if (clr_ptr_reg == LAST_ADDR) begin
        state_next   = RUN;
        clr_ptr_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  assign busy = (state_reg == CLEAR);

  logic              w_in_range, r_in_range, clr_we, wr_acc, rd_acc, fwd;
  logic [ADDR_W-1:0] lane_addr, r_idx;

  assign w_in_range = ({1'b0, w_addr} < DEPTH_X);
  assign r_in_range = ({1'b0, r_addr} < DEPTH_X);
  assign clr_we     = busy & ~rst;
  assign wr_acc     = ~busy & ~rst & enb & wr & w_in_range;
  assign rd_acc     = ~busy & ~rst & enb & rd;
  // An in-range write address matching implies the read address is in range too.
  assign fwd        = wr_acc & (w_addr == r_addr);
  assign lane_addr  = busy ? clr_ptr_reg : w_addr;
  assign r_idx      = r_in_range ? r_addr : '0;

  logic              s1_valid_reg, s1_oor_reg, s1_fwd_reg;
  logic [DATA_W-1:0] s1_wdata_reg;
  logic [NB-1:0]     s1_be_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_oor_reg   <= 1'b0;
      s1_fwd_reg   <= 1'b0;
      s1_wdata_reg <= '0;
      s1_be_reg    <= '0;
    end else begin
      s1_valid_reg <= rd_acc;
      s1_oor_reg   <= ~r_in_range;
      s1_fwd_reg   <= fwd;
      s1_wdata_reg <= w_data;
      s1_be_reg    <= w_be;
    end
  end

  logic [DATA_W-1:0] s1_data;
  logic [NB-1:0]     par_bad;
  logic              s1_err;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [LANE_W-1:0] lane_mem [DEPTH];
      logic [LANE_W-1:0] lane_rd_reg;
      logic [LANE_W-1:0] lane_wdata;
      logic              lane_we;
      logic              use_new;
`ifdef DP_MEM_PARITY_EN
      logic inj;
      assign inj        = (gi == 0) ? par_inj : 1'b0;
      assign lane_wdata = busy ? '0 : {(^w_data[gi*8 +: 8]) ^ inj, w_data[gi*8 +: 8]};
      // Forwarded bytes carry fresh data, so their stale stored parity is irrelevant.
      assign par_bad[gi] = ~use_new & (^lane_rd_reg);
`else
      assign lane_wdata  = busy ? '0 : w_data[gi*8 +: 8];
      assign par_bad[gi] = 1'b0;
`endif
      assign lane_we = clr_we | (wr_acc & w_be[gi]);

      always_ff @(posedge clk) begin
        if (lane_we)
          lane_mem[lane_addr] <= lane_wdata;
        lane_rd_reg <= lane_mem[r_idx];
      end

      assign use_new = s1_fwd_reg & s1_be_reg[gi];
      assign s1_data[gi*8 +: 8] = s1_oor_reg ? 8'h00 :
                                  (use_new ? s1_wdata_reg[gi*8 +: 8] : lane_rd_reg[7:0]);
    end
  endgenerate

`ifndef DP_MEM_PARITY_EN
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
`endif

  assign s1_err = s1_oor_reg | (|par_bad);

  logic              out_valid, out_err;
  logic [DATA_W-1:0] out_data;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid_reg, s2_err_reg;
      logic [DATA_W-1:0] s2_data_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_reg <= 1'b0;
          s2_err_reg   <= 1'b0;
          s2_data_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          s2_err_reg   <= s1_err;
          s2_data_reg  <= s1_data;
        end
      end
      assign out_valid = s2_valid_reg;
      assign out_err   = s2_err_reg;
      assign out_data  = s2_data_reg;
    end else begin : g_lat1
      assign out_valid = s1_valid_reg;
      assign out_err   = s1_err;
      assign out_data  = s1_data;
    end
  endgenerate

  logic [DATA_W-1:0] r_data_reg;
  logic              r_valid_reg, r_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_reg  <= '0;
      r_valid_reg <= 1'b0;
      r_err_reg   <= 1'b0;
    end else begin
      r_valid_reg <= out_valid;
      if (out_valid) begin
        r_data_reg <= out_data;
        r_err_reg  <= out_err;
      end
    end
  end

  assign r_data  = r_data_reg;
  assign r_valid = r_valid_reg;
  assign r_err   = r_err_reg;
endmodule

// File: tb/tb_dp_mem_param.sv
// Bench for dp_mem_param: a DEPTH=16/RD_LAT=1 and a DEPTH=12/RD_LAT=2 instance share one
// directed stimulus; a word-level model with a due-cycle schedule is checked every cycle.
module tb_dp_mem_param;
`ifdef DP_MEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enb, wr, rd, par_inj;
  logic [3:0]  w_addr, r_addr, w_be;
  logic [31:0] w_data;
  logic [31:0] r_data [2];
  logic        r_valid [2];
  logic        r_err [2];
  logic        busy [2];

  dp_mem_param #(.DATA_W(32), .DEPTH(16), .RD_LAT(1)) u_d16 (
    .clk(clk), .rst(rst), .enb(enb), .wr(wr), .w_addr(w_addr), .w_data(w_data),
    .w_be(w_be), .par_inj(par_inj), .rd(rd), .r_addr(r_addr),
    .r_data(r_data[0]), .r_valid(r_valid[0]), .r_err(r_err[0]), .busy(busy[0]));

  dp_mem_param #(.DATA_W(32), .DEPTH(12), .RD_LAT(2)) u_d12 (
    .clk(clk), .rst(rst), .enb(enb), .wr(wr), .w_addr(w_addr), .w_data(w_data),
    .w_be(w_be), .par_inj(par_inj), .rd(rd), .r_addr(r_addr),
    .r_data(r_data[1]), .r_valid(r_valid[1]), .r_err(r_err[1]), .busy(busy[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) old[b*8 +: 8] = nw[b*8 +: 8];
    return old;
  endfunction

  // Model state: words, byte-0 parity poison, clear progress, and results keyed by due cycle.
  int          dep [2] = '{16, 12};
  int          lat [2] = '{1, 2};
  logic [31:0] mm [2][16];
  logic        pb [2][16];
  int          cnt [2];
  logic        ev [2][8];
  logic [31:0] ed [2][8];
  logic        ee [2][8];
  int          cyc = 0;
  bit          started = 1'b0;
  int          vcnt [2];
  logic [31:0] last_d [2];
  logic        last_e [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; vcnt[i] = 0; last_d[i] = 0; last_e[i] = 0;
      for (int s = 0; s < 8; s++) begin ev[i][s] = 0; ed[i][s] = 0; ee[i][s] = 0; end
      for (int a = 0; a < 16; a++) begin mm[i][a] = 0; pb[i][a] = 0; end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) started = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        cnt[i] = 0;
        for (int s = 0; s < 8; s++) ev[i][s] = 0;
      end else if (cnt[i] < dep[i]) begin
        mm[i][cnt[i]] = 0;
        pb[i][cnt[i]] = 0;
        cnt[i]++;
      end else begin
        bit          wacc;
        logic [31:0] word;
        logic        e;
        int          slot;
        wacc = enb && wr && (int'(w_addr) < dep[i]);
        if (enb && rd) begin
          slot = (cyc + lat[i]) % 8;
          if (int'(r_addr) >= dep[i]) begin
            word = 0; e = 1'b1;
          end else begin
            word = mm[i][r_addr];
            e    = PAR_ON && pb[i][r_addr];
            if (wacc && w_addr == r_addr) begin
              word = merge(word, w_data, w_be);
              if (w_be[0]) e = 1'b0;
            end
          end
          ev[i][slot] = 1'b1; ed[i][slot] = word; ee[i][slot] = e;
        end
        if (wacc) begin
          mm[i][w_addr] = merge(mm[i][w_addr], w_data, w_be);
          if (w_be[0]) pb[i][w_addr] = PAR_ON && par_inj;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int s;
        s = cyc % 8;
        chk($sformatf("busy_d%0d_cyc%0d", i, cyc), 32'(busy[i]), 32'(cnt[i] < dep[i]));
        chk($sformatf("valid_d%0d_cyc%0d", i, cyc), 32'(r_valid[i]), 32'(ev[i][s]));
        if (ev[i][s]) begin
          chk($sformatf("data_d%0d_cyc%0d", i, cyc), r_data[i], ed[i][s]);
          chk($sformatf("err_d%0d_cyc%0d", i, cyc), 32'(r_err[i]), 32'(ee[i][s]));
          $display("read d%0d cyc %0d data %h err %0b", i, cyc, r_data[i], r_err[i]);
        end
        ev[i][s] = 1'b0;
        if (r_valid[i]) begin
          vcnt[i]++; last_d[i] = r_data[i]; last_e[i] = r_err[i];
        end
      end
    end
  end

  task automatic op(input bit w, input logic [3:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input bit inj, input bit r, input logic [3:0] ra);
    enb = 1'b1; wr = w; w_addr = wa; w_data = wd; w_be = be; par_inj = inj;
    rd = r; r_addr = ra;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; par_inj = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_both(input string name, input logic [31:0] d, input logic e);
    chk({name, "_d16_data"}, last_d[0], d);
    chk({name, "_d12_data"}, last_d[1], d);
    chk({name, "_d16_err"}, 32'(last_e[0]), 32'(e));
    chk({name, "_d12_err"}, 32'(last_e[1]), 32'(e));
  endtask

  initial begin
    int n0, n1, v0, v1, k;
    rst = 1'b1; enb = 1'b0; wr = 1'b0; rd = 1'b0; par_inj = 1'b0;
    w_addr = 0; r_addr = 0; w_be = 0; w_data = 0;
    repeat (2) @(negedge clk);
    chk("reset_d16_data", r_data[0], 32'h0);
    chk("reset_d12_valid", 32'(r_valid[1]), 32'h0);
    // Release reset while hammering a write to addr 2; it must be ignored during clear.
    rst = 1'b0; enb = 1'b1; wr = 1'b1; w_addr = 4'd2; w_data = 32'hFFFFFFFF; w_be = 4'hF;
    n0 = 0; n1 = 0;
    for (k = 0; k < 40; k++) begin
      if (k == 5) wr = 1'b0;
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      if (!busy[0] && !busy[1]) break;
      @(negedge clk);
    end
    wr = 1'b0;
    chk("clear_timeout", 32'(k < 40), 32'h1);
    chk("busy_cycles_d16", 32'(n0), 32'd16);
    chk("busy_cycles_d12", 32'(n1), 32'd12);

    op(0, 0, 0, 0, 0, 1, 4'd5); drain();
    expect_both("clear_rd5", 32'h0, 1'b0);
    chk("vcnt_d16_first", 32'(vcnt[0]), 32'd1);
    chk("vcnt_d12_first", 32'(vcnt[1]), 32'd1);

    op(0, 0, 0, 0, 0, 1, 4'd2); drain();
    expect_both("blocked_wr2", 32'h0, 1'b0);

    op(1, 4'd3, 32'hAABBCCDD, 4'b1111, 0, 0, 0);
    op(1, 4'd3, 32'h11223344, 4'b0101, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 4'd3); drain();
    expect_both("byte_en", 32'hAA22CC44, 1'b0);

    op(1, 4'd7, 32'hDEADBEEF, 4'b0011, 0, 1, 4'd7); drain();
    expect_both("rdw_fwd", 32'h0000BEEF, 1'b0);

    op(1, 4'd13, 32'hFFFFFFFF, 4'b1111, 0, 0, 0);
    op(0, 0, 0, 0, 0, 1, 4'd13); drain();
    chk("oor_d12_data", last_d[1], 32'h0);
    chk("oor_d12_err", 32'(last_e[1]), 32'h1);
    chk("inrange13_d16_data", last_d[0], 32'hFFFFFFFF);
    chk("inrange13_d16_err", 32'(last_e[0]), 32'h0);

    op(1, 4'd4, 32'h12345678, 4'b1111, 1, 0, 0);
    op(0, 0, 0, 0, 0, 1, 4'd4); drain();
    expect_both("parity_inj", 32'h12345678, PAR_ON);

    op(1, 4'd4, 32'h12345678, 4'b1111, 1, 1, 4'd4); drain();
    expect_both("parity_fwd", 32'h12345678, 1'b0);

    v0 = vcnt[0]; v1 = vcnt[1];
    op(0, 0, 0, 0, 0, 1, 4'd3);
    op(0, 0, 0, 0, 0, 1, 4'd7);
    op(0, 0, 0, 0, 0, 1, 4'd4); drain();
    chk("b2b_d16_count", 32'(vcnt[0] - v0), 32'd3);
    chk("b2b_d12_count", 32'(vcnt[1] - v1), 32'd3);
    chk("b2b_d16_last", last_d[0], PAR_ON ? 32'h12345678 : 32'h12345678);

    op(1, 4'd9, 32'h01020304, 4'b1111, 0, 1, 4'd3); drain();
    expect_both("indep_wr_rd", 32'hAA22CC44, 1'b0);

    v0 = vcnt[0]; v1 = vcnt[1];
    op(0, 0, 0, 0, 0, 1, 4'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while ((busy[0] || busy[1]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("reclear_timeout", 32'(busy[0] | busy[1]), 32'h0);
    chk("midrst_d16_novalid", 32'(vcnt[0]), 32'(v0));
    chk("midrst_d12_novalid", 32'(vcnt[1]), 32'(v1));

    op(0, 0, 0, 0, 0, 1, 4'd3); drain();
    expect_both("reclear_rd3", 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
